// File: rtl/score_display.sv
// Binary score to three-digit seven-segment display, converted by a
// sequential double-dabble (shift-and-add-3) FSM with registered outputs.
module score_display #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [11:0] Score,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam logic [6:0] SEG_BLANK    = 7'b1111111;
  localparam logic [6:0] SEG_ZERO     = 7'b1000000;
  localparam logic [6:0] HEX_LEAD_RST = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
  localparam logic [3:0] LAST_ITER    = 4'd11;

  state_t      state, state_next;
  logic [23:0] sr, sr_next, sr_corr;   // {bcd hundreds/tens/ones, binary}
  logic [3:0]  iter, iter_next;
  logic [11:0] shown, shown_next;
  logic [11:0] captured, captured_next;
  logic [11:0] score_clamped;
  logic [6:0]  hex0_next, hex1_next, hex2_next;
  logic        busy_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign score_clamped = (Score > 12'd999) ? 12'd999 : Score;

  always_comb begin
    // NOTE: every signal written here gets a hold default first, so no latch is inferred.
    state_next    = state;
    sr_next       = sr;
    iter_next     = iter;
    shown_next    = shown;
    captured_next = captured;
    hex0_next     = HEX0;
    hex1_next     = HEX1;
    hex2_next     = HEX2;
    sr_corr       = {add3(sr[23:20]), add3(sr[19:16]), add3(sr[15:12]), sr[11:0]};

    unique case (state)
      IDLE: begin
        if (Score != shown) begin
          captured_next = Score;
          sr_next       = {12'd0, score_clamped};
          iter_next     = 4'd0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        sr_next   = {sr_corr[22:0], 1'b0};
        iter_next = iter + 4'd1;
        if (iter == LAST_ITER) state_next = LOAD;
      end
      LOAD: begin
        // Hundreds zero blanks HEX2; hundreds and tens both zero also blanks HEX1.
        hex0_next  = seg7(sr[15:12]);
        hex1_next  = (BLANK_LEADING && sr[23:20] == 4'd0 && sr[19:16] == 4'd0)
                     ? SEG_BLANK : seg7(sr[19:16]);
        hex2_next  = (BLANK_LEADING && sr[23:20] == 4'd0) ? SEG_BLANK : seg7(sr[23:20]);
        shown_next = captured;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      sr       <= '0;
      iter     <= '0;
      shown    <= '0;
      captured <= '0;
      HEX0     <= SEG_ZERO;
      HEX1     <= HEX_LEAD_RST;
      HEX2     <= HEX_LEAD_RST;
      Busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_next;
      sr       <= sr_next;
      iter     <= iter_next;
      shown    <= shown_next;
      captured <= captured_next;
      HEX0     <= hex0_next;
      HEX1     <= hex1_next;
      HEX2     <= hex2_next;
      Busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed display scenarios plus
// randomized score traffic compared each cycle against a decimal-arithmetic model.
module tb_score_display;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ZERO  = 7'b1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] score = 12'd0;
  logic [6:0]  hex0, hex1, hex2, hex0_nb, hex1_nb, hex2_nb;
  logic        busy, busy_nb;

  int tests = 0;
  int fails = 0;

  // Model state: remaining busy cycles, captured raw score, last shown score.
  int          m_left = 0;
  logic [11:0] m_cap = 12'd0;
  logic [11:0] m_shown = 12'd0;
  logic [6:0]  m_hex [0:5];   // 0..2 blanking instance, 3..5 non-blanking

  score_display dut (
    .Clock(clk), .Reset(rst), .Score(score),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .Busy(busy)
  );

  score_display #(.BLANK_LEADING(1'b0)) dut_nb (
    .Clock(clk), .Reset(rst), .Score(score),
    .HEX0(hex0_nb), .HEX1(hex1_nb), .HEX2(hex2_nb), .Busy(busy_nb)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] table_v [0:9];
    table_v = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return table_v[d];
  endfunction

  task automatic model_display(input int value);
    int c, h, t, o;
    c = (value > 999) ? 999 : value;
    h = c / 100;
    t = (c / 10) % 10;
    o = c % 10;
    m_hex[0] = seg(o);
    m_hex[1] = (h == 0 && t == 0) ? BLANK : seg(t);
    m_hex[2] = (h == 0) ? BLANK : seg(h);
    m_hex[3] = seg(o);
    m_hex[4] = seg(t);
    m_hex[5] = seg(h);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  = 0;
      m_cap   = 12'd0;
      m_shown = 12'd0;
      m_hex[0] = ZERO; m_hex[1] = BLANK; m_hex[2] = BLANK;
      m_hex[3] = ZERO; m_hex[4] = ZERO;  m_hex[5] = ZERO;
    end else if (m_left == 0) begin
      if (score != m_shown) begin
        m_cap  = score;
        m_left = 13;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        model_display(int'(m_cap));
        m_shown = m_cap;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy",    32'(busy),    32'(m_left != 0));
    check("busy_nb", 32'(busy_nb), 32'(m_left != 0));
    check("hex0",    32'(hex0),    32'(m_hex[0]));
    check("hex1",    32'(hex1),    32'(m_hex[1]));
    check("hex2",    32'(hex2),    32'(m_hex[2]));
    check("hex0_nb", 32'(hex0_nb), 32'(m_hex[3]));
    check("hex1_nb", 32'(hex1_nb), 32'(m_hex[4]));
    check("hex2_nb", 32'(hex2_nb), 32'(m_hex[5]));
  end

  task automatic set_score(input logic [11:0] v);
    @(negedge clk);
    score = v;
  endtask

  // Waits one edge for a capture, then for Busy to fall, with a cycle budget.
  task automatic wait_idle();
    int budget;
    budget = 40;
    @(negedge clk);
    while (busy === 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still high after 40 cycles at %0t", $time);
    end
  endtask

  task automatic check_hex(input string name, input logic [6:0] h2, input logic [6:0] h1,
                           input logic [6:0] h0);
    check({name, "_hex2"}, 32'(hex2), 32'(h2));
    check({name, "_hex1"}, 32'(hex1), 32'(h1));
    check({name, "_hex0"}, 32'(hex0), 32'(h0));
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int busy_seen;
    int r;
    int hold;

    // Reset with Score=0: blank leading digits, no conversion afterwards.
    #1 rst = 1'b1;
    #1;
    check_hex("reset", BLANK, BLANK, ZERO);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_nb_hex1", 32'(hex1_nb), 32'(ZERO));
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    check("idle_after_reset", 32'(busy_seen), 32'd0);

    // 0 -> 7: Busy for exactly 13 sampled cycles, then ones digit only.
    set_score(12'd7);
    busy_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
    end
    check("seven_busy_cycles", 32'(busy_seen), 32'd13);
    check_hex("seven", BLANK, BLANK, 7'b1111000);

    // 105: tens zero still shown because hundreds is nonzero.
    set_score(12'd105);
    wait_idle();
    check_hex("s105", 7'b1111001, 7'b1000000, 7'b0010010);

    // Clamp: 1000 and 4095 each convert and both show 999.
    set_score(12'd1000);
    wait_idle();
    check_hex("s1000", 7'b0010000, 7'b0010000, 7'b0010000);
    set_score(12'd4095);
    @(negedge clk);
    check("s4095_retrigger", 32'(busy), 32'd1);
    wait_idle();
    check_hex("s4095", 7'b0010000, 7'b0010000, 7'b0010000);
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    check("hold_no_retrigger", 32'(busy_seen), 32'd0);

    // 12, then 345 on the 5th Busy cycle: 12 shows first, one idle cycle, then 345.
    set_score(12'd12);
    repeat (5) @(negedge clk);
    score = 12'd345;
    wait_idle();
    check_hex("s12", BLANK, 7'b1111001, 7'b0100100);
    @(negedge clk);
    check("s345_retrigger", 32'(busy), 32'd1);
    wait_idle();
    check_hex("s345", 7'b0110000, 7'b0011001, 7'b0010010);

    // Reset on the 6th Busy cycle of 999: immediate reset values, 999 never shown.
    set_score(12'd999);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_hex("abort", BLANK, BLANK, ZERO);
    check("abort_busy", 32'(busy), 32'd0);
    score = 12'd0;
    @(negedge clk);
    #1 rst = 1'b0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || hex2 !== BLANK) busy_seen++;
    end
    check("abort_quiet", 32'(busy_seen), 32'd0);

    // Randomized traffic, including changes mid-conversion and stray resets.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       set_score(12'($urandom_range(0, 9)));
        1:       set_score(12'($urandom_range(0, 999)));
        2:       set_score(12'($urandom_range(1000, 4095)));
        default: @(negedge clk);
      endcase
      hold = $urandom_range(0, 20);
      repeat (hold) @(negedge clk);
      if ($urandom_range(0, 30) == 0) reset_pulse();
    end
    wait_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
